// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // Supervisor states, in the order a clean power-up walks through them.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } pll_state_e;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    if (value >= max_value) begin
      sat_inc = max_value;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

  // Largest of four cycle counts; sizes the shared state timer.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    if (d > m) begin
      m = d;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop synchronizer for a single asynchronous level; all stages clear on reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences rPLL reset, qualifies LOCK, holds downstream reset, and watches for lock loss.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 27,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int LOCK_STABLE_CYCLES  = 2700,
  parameter int RESET_HOLD_CYCLES   = 1080000,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock_i,
  output logic             pll_reset_o,
  output logic             sys_rst_o,
  output logic             ready_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] loss_count_o,
  output logic [CNT_W-1:0] timeout_count_o
);

  localparam int TIMER_W = $clog2(max_of4(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                          LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)) + 1;
  localparam logic [TIMER_W-1:0] PLL_RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};

  pll_state_e         r_state;
  pll_state_e         w_next;
  logic [TIMER_W-1:0] r_timer;
  logic               w_lock_s;
  logic               w_timeout_evt;
  logic               w_loss_evt;
  logic               r_pll_reset;
  logic               r_sys_rst;
  logic               r_ready;
  logic               r_lock_lost;
  logic [CNT_W-1:0]   r_loss_count;
  logic [CNT_W-1:0]   r_timeout_count;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (pll_lock_i),
    .o_sync  (w_lock_s)
  );

  // Next-state decode; lock beats timeout when both happen on the same edge.
  always_comb begin
    w_next        = r_state;
    w_timeout_evt = 1'b0;
    w_loss_evt    = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_timer == PLL_RST_LAST) begin
          w_next = WAIT_LOCK;
        end else begin
          w_next = PLL_RST;
        end
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_next = STABLE;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_next        = PLL_RST;
          w_timeout_evt = 1'b1;
        end else begin
          w_next = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_next = WAIT_LOCK;
        end else if (r_timer == STABLE_LAST) begin
          w_next = HOLD;
        end else begin
          w_next = STABLE;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_next = WAIT_LOCK;
        end else if (r_timer == HOLD_LAST) begin
          w_next = RUN;
        end else begin
          w_next = HOLD;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_next     = WAIT_LOCK;
          w_loss_evt = 1'b1;
        end else begin
          w_next = RUN;
        end
      end
      default: begin
        w_next = PLL_RST;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PLL_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Shared timer: restarts on every state change, idles in RUN where nothing times out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_next != r_state) begin
      r_timer <= '0;
    end else if (r_state != RUN) begin
      r_timer <= r_timer + TIMER_W'(1);
    end else begin
      r_timer <= r_timer;
    end
  end

  // Outputs registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pll_reset     <= 1'b1;
      r_sys_rst       <= 1'b1;
      r_ready         <= 1'b0;
      r_lock_lost     <= 1'b0;
      r_loss_count    <= '0;
      r_timeout_count <= '0;
    end else begin
      r_pll_reset <= (w_next == PLL_RST);
      r_sys_rst   <= (w_next != RUN);
      r_ready     <= (w_next == RUN);
      r_lock_lost <= w_loss_evt;
      if (w_loss_evt) begin
        r_loss_count <= CNT_W'(sat_inc(32'(r_loss_count), 32'(CNT_MAX)));
      end else begin
        r_loss_count <= r_loss_count;
      end
      if (w_timeout_evt) begin
        r_timeout_count <= CNT_W'(sat_inc(32'(r_timeout_count), 32'(CNT_MAX)));
      end else begin
        r_timeout_count <= r_timeout_count;
      end
    end
  end

  assign pll_reset_o     = r_pll_reset;
  assign sys_rst_o       = r_sys_rst;
  assign ready_o         = r_ready;
  assign lock_lost_o     = r_lock_lost;
  assign loss_count_o    = r_loss_count;
  assign timeout_count_o = r_timeout_count;

endmodule
